// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T-flip-flop counter.
// Direction/mode encodings and the load clamp function.
package tff_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Clamp a load value to the top count; callers zero-extend to 32 bits.
  function automatic logic [31:0] clamp_to_max(
    input logic [31:0] din,
    input logic [31:0] max
  );
    return (din > max) ? max : din;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles when t is high.
// Reset value is set per bit so the counter can reset to any value.
module tff_cell
  import tff_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state is a toggle of the current bit when t is set.
  always_comb begin
    q_d = q_q ^ t;
  end

  // State bit with asynchronous reset to its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_BIT;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Up/down modulus counter built from T flip-flop cells.
// All state changes are expressed as a per-bit toggle mask.
module tff_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] tmask;
  logic [WIDTH-1:0] ld_val;
  logic             carry;
  logic             borrow;
  logic             sat_mode;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  assign sat_mode = (SATURATE == MODE_SAT);
  assign ld_val   = WIDTH'(clamp_to_max(32'(din), 32'(MAX_VAL)));

  // Toggle mask and flag next-state: clr > load > count.
  always_comb begin
    tmask  = '0;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    carry  = 1'b1;
    borrow = 1'b1;
    if (clr) begin
      tmask = q;
      ovf_d = 1'b0;
    end else if (load) begin
      tmask = q ^ ld_val;
    end else if (en) begin
      if (q > MAX_VAL) begin
        tmask = q;
      end else if (up == DIR_UP) begin
        if (q == MAX_VAL) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          tmask = sat_mode ? '0 : q;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            tmask[i] = carry;
            carry    = carry & q[i];
          end
        end
      end else begin
        if (q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          tmask = sat_mode ? '0 : MAX_VAL;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            tmask[i] = borrow;
            borrow   = borrow & ~q[i];
          end
        end
      end
    end
  end

  // One T cell per count bit, each with its own reset bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .t  (tmask[i]),
      .q  (q[i])
    );
  end

  // Terminal-count pulse and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: wrap, saturate and
// non-zero reset builds driven from shared inputs.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up;
  logic [3:0] din;
  logic [3:0] q_w, q_s, q_r;
  logic       tc_w, tc_s, tc_r;
  logic       ovf_w, ovf_s, ovf_r;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
    .en(en), .up(up), .q(q_w), .tc(tc_w), .ovf(ovf_w));

  tff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
    .en(en), .up(up), .q(q_s), .tc(tc_s), .ovf(ovf_s));

  tff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd6), .SATURATE(1'b0)) u_r (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
    .en(en), .up(up), .q(q_r), .tc(tc_r), .ovf(ovf_r));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = '0;
    #3;
    chk("rst_q_w", q_w, 0);
    chk("rst_tc_w", tc_w, 0);
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_q_r", q_r, 6);
    @(posedge clk);
    #2 rst = 1'b0;

    // idle edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_q", q_w, 0);
      chk("idle_tc", tc_w, 0);
      chk("idle_ovf", ovf_w, 0);
      chk("idle_q_r", q_r, 6);
    end

    // count up 12 edges
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("up_q_w", q_w, i % 10);
      chk("up_tc_w", tc_w, (i == 10));
      chk("up_ovf_w", ovf_w, (i >= 10));
      chk("up_q_s", q_s, (i > 9) ? 9 : i);
      chk("up_tc_s", tc_s, (i >= 10));
      chk("up_q_r", q_r, (6 + i) % 10);
      chk("up_tc_r", tc_r, (i == 4));
    end

    // clear then count down from zero
    en = 1'b0; clr = 1'b1;
    step();
    chk("clr_q_w", q_w, 0);
    chk("clr_ovf_w", ovf_w, 0);
    chk("clr_tc_s", tc_s, 0);
    chk("clr_q_r", q_r, 0);
    clr = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("dn_q_w", q_w, 10 - i);
      chk("dn_tc_w", tc_w, (i == 1));
      chk("dn_ovf_w", ovf_w, 1);
      chk("dn_q_s", q_s, 0);
      chk("dn_tc_s", tc_s, 1);
    end

    // load clamp, load beats count, direction change
    en = 1'b0; load = 1'b1; din = 4'hF;
    step();
    chk("ld_clamp_w", q_w, 9);
    chk("ld_clamp_s", q_s, 9);
    chk("ld_tc_w", tc_w, 0);
    din = 4'd5; en = 1'b1; up = 1'b1;
    step();
    chk("ld_beats_en", q_w, 5);
    chk("ld_ovf_keep", ovf_w, 1);
    load = 1'b0;
    step();
    chk("dir_up", q_w, 6);
    up = 1'b0;
    step();
    chk("dir_dn", q_w, 5);
    step();
    chk("dir_dn2", q_w, 4);

    // clr and load together
    en = 1'b0; clr = 1'b1; load = 1'b1; din = 4'd3;
    step();
    chk("clrld_q", q_w, 0);
    chk("clrld_ovf", ovf_w, 0);
    clr = 1'b0;

    // async reset mid-cycle
    din = 4'd7;
    step();
    chk("pre_rst_q", q_w, 7);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_q_w", q_w, 0);
    chk("async_q_r", q_r, 6);
    chk("async_tc_w", tc_w, 0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_q", q_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
